// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and defaults for the PC / instruction-fetch sequencer.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

    localparam logic [7:0] DEF_RESET_PC = 8'h00;
    localparam logic [7:0] DEF_PC_STEP  = 8'h04;
    localparam int         DEF_IW       = 32;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bundle of the fetch unit's control, adder, imem and decode-side signals.
interface pc_fetch_unit_if #(
    parameter int IW = 32
);
    logic          en;
    logic          halt;
    logic [7:0]    pc_out;
    logic [7:0]    pc_step;
    logic [7:0]    pc_sum;
    logic          branch_valid;
    logic [7:0]    branch_target;
    logic          imem_req;
    logic          imem_ack;
    logic [IW-1:0] imem_data;
    logic          instr_valid;
    logic [IW-1:0] instr;
    logic [7:0]    instr_pc;
    logic          instr_ready;

    modport master (
        input  en, halt, pc_sum, branch_valid, branch_target,
               imem_ack, imem_data, instr_ready,
        output pc_out, pc_step, imem_req, instr_valid, instr, instr_pc
    );

    modport slave (
        output en, halt, pc_sum, branch_valid, branch_target,
               imem_ack, imem_data, instr_ready,
        input  pc_out, pc_step, imem_req, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register, fetch FSM and one-entry instruction buffer. The PC adder
// lives outside; this block drives its operands and registers its sum.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [7:0] RESET_PC = DEF_RESET_PC,
    parameter logic [7:0] PC_STEP  = DEF_PC_STEP,
    parameter int         IW       = DEF_IW
) (
    input logic             clk,
    input logic             reset,
    pc_fetch_unit_if.master bus
);

    fetch_state_e  state_q;
    logic [7:0]    pc_q;
    logic          instr_valid_q;
    logic [IW-1:0] instr_q;
    logic [7:0]    instr_pc_q;

    logic slot_free;
    logic ack_hon;
    logic consume;

    // Request is combinational so a reset or a full buffer withdraws it at once.
    assign slot_free    = !instr_valid_q || bus.instr_ready;
    assign bus.imem_req = (state_q == ST_REQ) && slot_free;
    assign ack_hon      = bus.imem_req && bus.imem_ack;
    assign consume      = instr_valid_q && bus.instr_ready;

    assign bus.pc_out      = pc_q;
    assign bus.pc_step     = PC_STEP;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;

    // NOTE: non-blocking assignments only; later assignments in the block
    // override the consume default when a reload or flush happens.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            if (consume) instr_valid_q <= 1'b0;

            if (bus.halt || state_q == ST_HALT) begin
                state_q <= ST_HALT;
            end else if (bus.branch_valid) begin
                pc_q          <= bus.branch_target;
                instr_valid_q <= 1'b0;
                state_q       <= bus.en ? ST_REQ : ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE: if (bus.en) state_q <= ST_REQ;
                    ST_REQ: begin
                        if (ack_hon) begin
                            instr_q       <= bus.imem_data;
                            instr_pc_q    <= pc_q;
                            instr_valid_q <= 1'b1;
                            pc_q          <= bus.pc_sum;
                            state_q       <= bus.en ? ST_REQ : ST_IDLE;
                        end else if (!slot_free) begin
                            state_q <= ST_WAIT;
                        end
                    end
                    ST_WAIT: if (slot_free) state_q <= bus.en ? ST_REQ : ST_IDLE;
                    default: state_q <= ST_HALT;
                endcase
            end
        end
    end

endmodule
